fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Sits between the context manager's fetch request path and decode.
- Drives the fetch stage's `order`/`pc` lookup port every cycle it may issue.
- Retries the same PC on a cache miss (`done`=0); on a hit, pushes {pc, instr} into a small FIFO and advances the PC by 4.
- Presents the FIFO head to decode with a valid/ready handshake; a redirect (branch/jump) flushes the FIFO and restarts at a new PC.

Parameters:
- LOG_DEPTH, 2, log2 of FIFO entries.
- DEPTH, 2**LOG_DEPTH, FIFO entries (derived; do not override).
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  leave STOP, begin fetching at start_pc.
- start_pc  in  `LEN_WORD  first PC after start.
- halt  in  1  enter STOP (e.g. prold mode); no further orders.
- redirect  in  1  flush FIFO, continue from redirect_pc.
- redirect_pc  in  `LEN_WORD  new PC on redirect.
- order  out  1  fetch lookup request (combinational from state).
- pc  out  `LEN_WORD  PC being looked up.
- done  in  1  fetch hit, same cycle as order.
- instr  in  `LEN_INST  instruction, valid when done=1.
- out_valid  out  1  FIFO non-empty.
- out_pc  out  `LEN_WORD  head PC.
- out_instr  out  `LEN_INST  head instruction.
- out_ready  in  1  decode accepts head this cycle.

Behaviour:
- States: STOP, RUN.
  - Reset enters STOP with pc_reg=RESET_PC, FIFO empty (rd_ptr=wr_ptr=0, count=0).
  - Outputs in reset: order=0, pc=RESET_PC, out_valid=0.
- STOP:
  - order=0.
  - start=1: pc_reg<=start_pc, go to RUN.
  - redirect=1 (without start): pc_reg<=redirect_pc and FIFO flushed; stays STOP.
- RUN:
  - order = ~halt & ~redirect & (count!=DEPTH); pc=pc_reg.
  - order&done: write {pc_reg, instr} at wr_ptr; pc_reg<=pc_reg+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - order&~done: pc_reg unchanged; the lookup is retried next cycle.
  - halt=1: go to STOP next cycle. The FIFO is kept and keeps draining.
- Priority when several controls are asserted in one cycle: rst > redirect > halt > start.
  - redirect takes effect in STOP or RUN: FIFO cleared, pc_reg<=redirect_pc, state unchanged.
  - start while in RUN is ignored.
- Pop: out_valid&out_ready advances rd_ptr.
  - Pop in a redirect cycle counts as accepted but is irrelevant, since the FIFO is cleared at that edge.
- Simultaneous push and pop: count unchanged; pointers both advance modulo DEPTH.
- Full condition:
  - Full is count==DEPTH. No order is issued when full, even if a pop happens the same cycle (no bypass).
  - Worst case one bubble after draining from full.
- Empty condition: out_valid=0; out_pc/out_instr are don't-care. No same-cycle fetch-to-output bypass.
- Latency:
  - start at cycle t -> order=1 at t+1.
  - A hit at t+1 -> out_valid=1 at t+2.
  - Steady hits give one instruction per cycle.
- count is LOG_DEPTH+1 bits. Pointers are LOG_DEPTH bits and wrap naturally.
- rst mid-operation: all state returns to reset values on the next edge; in-flight data is discarded.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined, adds two outputs:
  - stat_miss_cnt (32): counts cycles with order&~done.
  - stat_full_cnt (32): counts RUN cycles with ~halt&~redirect&count==DEPTH.
- Both counters saturate at 32'hFFFF_FFFF and clear on rst only (not on redirect).
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, start=1 start_pc=0x100, done always 1, out_ready=1 -> order at cycle 1; outputs 0x100, 0x104, 0x108 on consecutive cycles from cycle 2.
- done=0 for 3 cycles at pc=0x200, then 1 -> pc held at 0x200 for 4 orders; exactly one entry pushed for 0x200; next order at 0x204.
- out_ready=0, DEPTH=4, hits -> 4 entries 0x0..0xC; order drops to 0 at count 4; release out_ready -> entries emerge in order, fetching resumes at 0x10.
- FIFO holds 3 entries; redirect=1 redirect_pc=0x800 -> next cycle out_valid=0; order resumes with pc=0x800; old entries never appear.
- halt=1 in RUN with 2 entries -> no order from the following cycle; both entries still drain; start with start_pc=0x40 resumes at 0x40.
- With FETCH_QUEUE_STATS_EN: 5 miss cycles plus 2 full cycles -> stat_miss_cnt=5, stat_full_cnt=2; redirect leaves both unchanged; rst clears both to 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: issues sequential PC lookups, retries on miss, buffers hits for decode.
// Optional statistics counters are enabled with FETCH_QUEUE_STATS_EN.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif

module fetch_queue #(
    parameter int LOG_DEPTH = 2,
    localparam int DEPTH = 2 ** LOG_DEPTH,
    parameter logic [`LEN_WORD-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [`LEN_WORD-1:0] start_pc,
    input  logic                 halt,
    input  logic                 redirect,
    input  logic [`LEN_WORD-1:0] redirect_pc,
    output logic                 order,
    output logic [`LEN_WORD-1:0] pc,
    input  logic                 done,
    input  logic [`LEN_INST-1:0] instr,
    output logic                 out_valid,
    output logic [`LEN_WORD-1:0] out_pc,
    output logic [`LEN_INST-1:0] out_instr,
`ifdef FETCH_QUEUE_STATS_EN
    input  logic                 out_ready,
    output logic [31:0]          stat_miss_cnt,
    output logic [31:0]          stat_full_cnt
`else
    input  logic                 out_ready
`endif
);

    typedef enum logic {STOP, RUN} state_t;

    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

    state_t                 state;
    state_t                 state_next;
    logic [`LEN_WORD-1:0]   pc_reg;
    logic [LOG_DEPTH-1:0]   rd_ptr;
    logic [LOG_DEPTH-1:0]   wr_ptr;
    logic [LOG_DEPTH:0]     count;
    logic [`LEN_WORD-1:0]   mem_pc    [DEPTH];
    logic [`LEN_INST-1:0]   mem_instr [DEPTH];
    logic                   push;
    logic                   pop;
    logic                   full;

    assign full      = (count == FULL_COUNT);
    assign push      = order & done;
    assign pop       = out_valid & out_ready;
    assign pc        = pc_reg;
    assign out_valid = (count != '0);
    assign out_pc    = mem_pc[rd_ptr];
    assign out_instr = mem_instr[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    // Redirect freezes the state; halt outranks start, and start only matters in STOP.
    always_comb begin
        state_next = state;
        if (!redirect) begin
            if (halt) begin
                state_next = STOP;
            end else if (state == STOP && start) begin
                state_next = RUN;
            end
        end
    end

    // No order while full, even if a pop frees a slot this cycle.
    always_comb begin
        order = 1'b0;
        if (state == RUN && !halt && !redirect && !full) begin
            order = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc_reg <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (state == STOP && start && !halt) begin
                pc_reg <= start_pc;
            end else if (push) begin
                pc_reg <= pc_reg + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= pc_reg;
            mem_instr[wr_ptr] <= instr;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic miss_cycle;
    logic full_cycle;

    assign miss_cycle = order & ~done;
    assign full_cycle = (state == RUN) & ~halt & ~redirect & full;

    // Saturating counters; only reset clears them, redirect leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_miss_cnt <= '0;
            stat_full_cnt <= '0;
        end else begin
            if (miss_cycle && stat_miss_cnt != 32'hFFFF_FFFF) begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
            if (full_cycle && stat_full_cnt != 32'hFFFF_FFFF) begin
                stat_full_cnt <= stat_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: each step drives inputs at negedge and checks just after.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        order;
    logic [31:0] pc;
    logic        done;
    logic [31:0] instr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_miss_cnt;
    logic [31:0] stat_full_cnt;
`endif

    int tests = 0;
    int failures = 0;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .order       (order),
        .pc          (pc),
        .done        (done),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
`ifdef FETCH_QUEUE_STATS_EN
        .out_ready   (out_ready),
        .stat_miss_cnt (stat_miss_cnt),
        .stat_full_cnt (stat_full_cnt)
`else
        .out_ready   (out_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the fake cache returns for a given PC.
    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [31:0] sp, input logic h,
                                 input logic r, input logic [31:0] rp, input logic d,
                                 input logic [31:0] ipc, input logic rdy);
        start       = s;
        start_pc    = sp;
        halt        = h;
        redirect    = r;
        redirect_pc = rp;
        done        = d;
        instr       = instrFor(ipc);
        out_ready   = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic e_order, input logic [31:0] e_pc,
                               input logic e_valid, input logic [31:0] e_out_pc);
        #1;
        cmp({tag, ".order"}, {31'd0, order}, {31'd0, e_order});
        cmp({tag, ".pc"}, pc, e_pc);
        cmp({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
        if (e_valid) begin
            cmp({tag, ".out_pc"}, out_pc, e_out_pc);
            cmp({tag, ".out_instr"}, out_instr, instrFor(e_out_pc));
        end
        @(negedge clk);
    endtask

`ifdef FETCH_QUEUE_STATS_EN
    task automatic checkStats(input string tag, input logic [31:0] e_miss, input logic [31:0] e_full);
        #1;
        cmp({tag, ".miss"}, stat_miss_cnt, e_miss);
        cmp({tag, ".full"}, stat_full_cnt, e_full);
    endtask
`endif

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset", 0, 32'h0, 0, 0);
        rst = 1'b0;

        // Start at 0x100 with every lookup hitting.
        applyStimulus(1, 32'h100, 0, 0, 0, 1, 32'h0, 1);   checkOutput("t1_stop", 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h100, 1);       checkOutput("t1_first", 1, 32'h100, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h104, 1);       checkOutput("t1_out0", 1, 32'h104, 1, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h108, 1);       checkOutput("t1_out1", 1, 32'h108, 1, 32'h104);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10C, 1);       checkOutput("t1_out2", 1, 32'h10C, 1, 32'h108);

        // Three misses at 0x200 then a hit: exactly one entry.
        applyStimulus(0, 0, 0, 1, 32'h200, 1, 32'h110, 1); checkOutput("t2_redir", 0, 32'h110, 1, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h200, 1);   checkOutput("t2_miss", 1, 32'h200, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h200, 0);       checkOutput("t2_hit", 1, 32'h200, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h204, 0);       checkOutput("t2_next", 1, 32'h204, 1, 32'h200);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h204, 1);       checkOutput("t2_pop", 1, 32'h204, 1, 32'h200);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h204, 1);       checkOutput("t2_one", 1, 32'h204, 0, 0);

        // Fill to DEPTH with decode stalled, then release.
        applyStimulus(0, 0, 0, 1, 32'h0, 0, 32'h204, 0);   checkOutput("t3_redir", 0, 32'h204, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 0);         checkOutput("t3_fill0", 1, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h4, 0);         checkOutput("t3_fill1", 1, 32'h4, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8, 0);         checkOutput("t3_fill2", 1, 32'h8, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hC, 0);         checkOutput("t3_fill3", 1, 32'hC, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10, 1);        checkOutput("t3_full", 0, 32'h10, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10, 1);        checkOutput("t3_resume", 1, 32'h10, 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h14, 1);        checkOutput("t3_drain1", 1, 32'h14, 1, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h18, 1);        checkOutput("t3_drain2", 1, 32'h18, 1, 32'hC);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1C, 1);        checkOutput("t3_drain3", 1, 32'h1C, 1, 32'h10);

        // Three entries pending when a redirect to 0x800 arrives.
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h20, 0);        checkOutput("t4_hold", 1, 32'h20, 1, 32'h14);
        applyStimulus(0, 0, 0, 1, 32'h800, 0, 32'h20, 0);  checkOutput("t4_redir", 0, 32'h20, 1, 32'h14);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h800, 1);       checkOutput("t4_flushed", 1, 32'h800, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h804, 1);       checkOutput("t4_new", 1, 32'h804, 1, 32'h800);

        // Halt with two entries; they drain, then restart at 0x40.
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h808, 0);       checkOutput("t5_fill", 1, 32'h808, 1, 32'h804);
        applyStimulus(0, 0, 1, 0, 0, 1, 32'h80C, 0);       checkOutput("t5_halt", 0, 32'h80C, 1, 32'h804);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h80C, 1);       checkOutput("t5_drain1", 0, 32'h80C, 1, 32'h804);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h80C, 1);       checkOutput("t5_drain2", 0, 32'h80C, 1, 32'h808);
        applyStimulus(1, 32'h40, 0, 0, 0, 1, 32'h80C, 1);  checkOutput("t5_start", 0, 32'h80C, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h40, 1);        checkOutput("t5_resume", 1, 32'h40, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h44, 1);        checkOutput("t5_out", 1, 32'h44, 1, 32'h40);

        // PC wraps from 0xFFFF_FFFC to 0.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h48, 1); checkOutput("wrap_redir", 0, 32'h48, 1, 32'h44);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);      checkOutput("wrap_hit", 1, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 1);              checkOutput("wrap_zero", 1, 32'h0, 1, 32'hFFFF_FFFC);

        // Start in RUN is ignored; redirect beats halt and keeps RUN.
        applyStimulus(1, 32'h900, 0, 0, 0, 1, 32'h4, 1);   checkOutput("run_start", 1, 32'h4, 1, 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h300, 1, 32'h8, 1);   checkOutput("redir_halt", 0, 32'h8, 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h300, 1);       checkOutput("redir_run", 1, 32'h300, 0, 0);

        // Reset mid-operation discards everything.
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h304, 1);       checkOutput("rst_pre", 1, 32'h304, 1, 32'h300);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 1);         checkOutput("rst_mid", 0, 32'h0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 1);         checkOutput("rst_stop", 0, 32'h0, 0, 0);

`ifdef FETCH_QUEUE_STATS_EN
        // Five misses, two full cycles, then redirect and reset behaviour.
        checkStats("s_zero", 0, 0);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 32'h0, 0);     checkOutput("s_start", 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);     checkOutput("s_miss", 1, 32'h0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 0);         checkOutput("s_fill0", 1, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h4, 0);         checkOutput("s_fill1", 1, 32'h4, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8, 0);         checkOutput("s_fill2", 1, 32'h8, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hC, 0);         checkOutput("s_fill3", 1, 32'hC, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10, 0);        checkOutput("s_full0", 0, 32'h10, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h10, 0);        checkOutput("s_full1", 0, 32'h10, 1, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h500, 0, 32'h10, 0);  checkOutput("s_redir", 0, 32'h10, 1, 32'h0);
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h500, 0);
        checkStats("s_counts", 5, 2);
        checkOutput("s_halt", 0, 32'h500, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h500, 0);       checkOutput("s_rst", 0, 32'h500, 0, 0);
        checkStats("s_clear", 0, 0);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
